div_sqrt_issue_arbiter: RTL and testbench
=========================================

// Module: div_sqrt_issue_arbiter
// PURPOSE
//  Shares one DivSqrtRecF64 unit between NUM_REQ requesters (e.g. two FP issue ports).
//  Round-robin selects a request the unit can accept for that op type, issues it, and tracks the single in-flight op.
//  Captures the one-cycle result pulse into a hold register and returns it to the owner with a ready/valid handshake.
//  Supports per-requester flush of in-flight work and a latency watchdog.
// PARAMETERS
//  NUM_REQ  2    number of requesters (>=2)
//  TAG_W    5    width of opaque requester tag carried with each op
//  MAX_LAT  127  BUSY cycles before watchdog fires (must exceed worst-case unit latency)
// PORTS
//  clock              in   1              clock
//  reset              in   1              asynchronous reset, active low
//  req_valid          in   NUM_REQ        request valid per requester
//  req_ready          out  NUM_REQ        request accepted (grant) per requester
//  req_sqrt           in   NUM_REQ        1=sqrt, 0=div
//  req_a / req_b      in   NUM_REQ*65     recoded F64 operands, requester i at [65*i+:65]
//  req_rm             in   NUM_REQ*3      rounding mode
//  req_is_snan        in   NUM_REQ*4      isSNaN/subnormal qualifiers
//  req_tag            in   NUM_REQ*TAG_W  tag returned with result
//  flush              in   NUM_REQ        kill requester i's pending/in-flight op
//  resp_valid         out  NUM_REQ        result valid, owner only
//  resp_ready         in   NUM_REQ        result consumed
//  resp_out           out  65             recoded result
//  resp_exc           out  5              exceptionFlags
//  resp_u_exc         out  7              u_exception
//  resp_u_flag        out  10             u_flag
//  resp_tag           out  TAG_W          tag of op in resp
//  ds_in_ready_div    in   1              unit can accept div
//  ds_in_ready_sqrt   in   1              unit can accept sqrt
//  ds_in_valid        out  1              issue strobe to unit
//  ds_sqrt_op, ds_a, ds_b, ds_rm, ds_is_snan  out  1/65/65/3/4  operands to unit
//  ds_out_valid_div   in   1              div result pulse
//  ds_out_valid_sqrt  in   1              sqrt result pulse
//  ds_out, ds_exc, ds_u_exc, ds_u_flag    in   65/5/7/10     unit result fields
//  busy               out  1              state != IDLE
//  timeout_err        out  1              sticky watchdog error
// BEHAVIOUR
//  States: IDLE, BUSY, RESP. Reset -> IDLE; all outputs 0; hold regs, tag, owner, rr_ptr, wdog, timeout_err = 0.
//  IDLE: eligible[i] = req_valid[i] & ~flush[i] & (req_sqrt[i] ? ds_in_ready_sqrt : ds_in_ready_div).
//   Grant = first eligible from rr_ptr upward (mod NUM_REQ); req_ready = onehot grant, combinational, IDLE only.
//   ds_in_valid = |grant; ds_* operands muxed combinationally from granted requester (0 when no grant).
//   On grant: latch owner, op, tag; rr_ptr <= owner+1 (wrap to 0); wdog <= 0; -> BUSY.
//  BUSY: ds_in_valid=0; wdog increments each cycle.
//   Completion = (op ? ds_out_valid_sqrt : ds_out_valid_div); pulse of the other type is ignored.
//   Completion & ~flush[owner] -> latch ds_out/exc/u_exc/u_flag into hold regs, -> RESP.
//   flush[owner] (any BUSY cycle, including completion cycle) -> set kill; completion with kill -> IDLE, result dropped.
//   kill persists until completion; flush of non-owner in BUSY has no effect.
//   wdog == MAX_LAT-1 without completion -> timeout_err <= 1 (sticky until reset), -> IDLE, op dropped.
//  RESP: resp_valid[owner]=1, resp_* driven from hold regs (stable while waiting).
//   resp_ready[owner] -> IDLE next cycle. flush[owner] -> IDLE, response dropped (flush wins over ready).
//  No issue outside IDLE: one op in flight; back-to-back ops separated by >=1 IDLE cycle.
//  Asynchronous reset mid-op returns to IDLE immediately; the unit's late result pulse after reset is ignored (IDLE).
// TESTING
//  1 req0 div, unit ready, result after 12 cycles, resp_ready=1 -> resp_valid[0] 1 cycle, resp_tag=req_tag0, resp_out=ds_out.
//  2 req0 and req1 valid every cycle, 4 ops -> grants alternate 0,1,0,1; rr_ptr wraps to 0.
//  3 req1 sqrt, ds_in_ready_sqrt=0, req0 div ready -> req0 granted; req1 granted once ready_sqrt=1.
//  4 flush[0] on BUSY cycle 3 -> no resp_valid, busy drops after completion pulse; flush[1] mid-op -> no effect.
//  5 resp_ready held 0 for 5 cycles -> resp_* stable, no new grant; ready=1 -> IDLE, next grant following cycle.
//  6 no completion for MAX_LAT cycles -> timeout_err=1 sticky, state IDLE; reset low mid-BUSY -> all outputs 0.

Source files
------------

// File: rtl/div_sqrt_issue_arbiter_if.sv
// Requester, response and DivSqrt unit signals shared by the issue arbiter.
// The slave modport is the arbiter's view; master is the requester/unit side.
interface div_sqrt_issue_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_sqrt;
  logic [NUM_REQ*65-1:0]    req_a;
  logic [NUM_REQ*65-1:0]    req_b;
  logic [NUM_REQ*3-1:0]     req_rm;
  logic [NUM_REQ*4-1:0]     req_is_snan;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       flush;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [64:0]              resp_out;
  logic [4:0]               resp_exc;
  logic [6:0]               resp_u_exc;
  logic [9:0]               resp_u_flag;
  logic [TAG_W-1:0]         resp_tag;
  logic                     ds_in_ready_div;
  logic                     ds_in_ready_sqrt;
  logic                     ds_in_valid;
  logic                     ds_sqrt_op;
  logic [64:0]              ds_a;
  logic [64:0]              ds_b;
  logic [2:0]               ds_rm;
  logic [3:0]               ds_is_snan;
  logic                     ds_out_valid_div;
  logic                     ds_out_valid_sqrt;
  logic [64:0]              ds_out;
  logic [4:0]               ds_exc;
  logic [6:0]               ds_u_exc;
  logic [9:0]               ds_u_flag;

  modport slave (
    input  req_valid, req_sqrt, req_a, req_b, req_rm, req_is_snan, req_tag, flush,
    input  resp_ready, ds_in_ready_div, ds_in_ready_sqrt,
    input  ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_exc, ds_u_exc, ds_u_flag,
    output req_ready, resp_valid, resp_out, resp_exc, resp_u_exc, resp_u_flag, resp_tag,
    output ds_in_valid, ds_sqrt_op, ds_a, ds_b, ds_rm, ds_is_snan
  );

  modport master (
    output req_valid, req_sqrt, req_a, req_b, req_rm, req_is_snan, req_tag, flush,
    output resp_ready, ds_in_ready_div, ds_in_ready_sqrt,
    output ds_out_valid_div, ds_out_valid_sqrt, ds_out, ds_exc, ds_u_exc, ds_u_flag,
    input  req_ready, resp_valid, resp_out, resp_exc, resp_u_exc, resp_u_flag, resp_tag,
    input  ds_in_valid, ds_sqrt_op, ds_a, ds_b, ds_rm, ds_is_snan
  );
endinterface

// File: rtl/div_sqrt_issue_arbiter.sv
// Round-robin issue arbiter sharing one DivSqrtRecF64 unit between NUM_REQ requesters,
// tracking the single in-flight op and holding its result until the owner consumes it.
module div_sqrt_issue_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 5,
  parameter int MAX_LAT = 127
) (
  input  logic                      clock,
  input  logic                      reset,
  div_sqrt_issue_arbiter_if.slave   io,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDOG_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef logic [IDX_W-1:0] idx_t;

  state_t            stateQ, stateD;
  idx_t              owner, rrPtr, grantIdx;
  logic              grantValid, opSqrt, kill, completion, flushOwner, wdogDone;
  logic [TAG_W-1:0]  tagQ;
  logic [WDOG_W-1:0] wdog;
  logic [64:0]       holdOut;
  logic [4:0]        holdExc;
  logic [6:0]        holdUExc;
  logic [9:0]        holdUFlag;
  logic [NUM_REQ-1:0] eligible;
  logic [64:0]       reqA [NUM_REQ];
  logic [64:0]       reqB [NUM_REQ];
  logic [2:0]        reqRm [NUM_REQ];
  logic [3:0]        reqIsSnan [NUM_REQ];
  logic [TAG_W-1:0]  reqTag [NUM_REQ];

  always_comb begin : unpack
    for (int i = 0; i < NUM_REQ; i++) begin
      reqA[i]      = io.req_a[65*i +: 65];
      reqB[i]      = io.req_b[65*i +: 65];
      reqRm[i]     = io.req_rm[3*i +: 3];
      reqIsSnan[i] = io.req_is_snan[4*i +: 4];
      reqTag[i]    = io.req_tag[TAG_W*i +: TAG_W];
      eligible[i]  = io.req_valid[i] & ~io.flush[i] &
                     (io.req_sqrt[i] ? io.ds_in_ready_sqrt : io.ds_in_ready_div);
    end
  end

  always_comb begin : pick
    int cand;
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    // Gated by reset so a request held across reset cannot leak a grant.
    if (stateQ == IDLE && reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rrPtr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!grantValid && eligible[idx_t'(cand)]) begin
          grantValid = 1'b1;
          grantIdx   = idx_t'(cand);
        end
      end
    end
  end

  assign completion = opSqrt ? io.ds_out_valid_sqrt : io.ds_out_valid_div;
  assign flushOwner = io.flush[owner];
  assign wdogDone   = (wdog == WDOG_W'(MAX_LAT - 1));
  assign busy       = (stateQ != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin : fsm
    // NOTE: every output and the next state get a default first, so no path infers a latch.
    stateD         = stateQ;
    io.req_ready   = '0;
    io.ds_in_valid = grantValid;
    io.ds_sqrt_op  = 1'b0;
    io.ds_a        = '0;
    io.ds_b        = '0;
    io.ds_rm       = '0;
    io.ds_is_snan  = '0;
    io.resp_valid  = '0;
    io.resp_out    = holdOut;
    io.resp_exc    = holdExc;
    io.resp_u_exc  = holdUExc;
    io.resp_u_flag = holdUFlag;
    io.resp_tag    = tagQ;
    if (grantValid) begin
      io.req_ready[grantIdx] = 1'b1;
      io.ds_sqrt_op          = io.req_sqrt[grantIdx];
      io.ds_a                = reqA[grantIdx];
      io.ds_b                = reqB[grantIdx];
      io.ds_rm               = reqRm[grantIdx];
      io.ds_is_snan          = reqIsSnan[grantIdx];
    end
    case (stateQ)
      IDLE: if (grantValid) stateD = BUSY;
      BUSY: begin
        if (completion)    stateD = (kill | flushOwner) ? IDLE : RESP;
        else if (wdogDone) stateD = IDLE;
      end
      RESP: begin
        io.resp_valid[owner] = 1'b1;
        if (flushOwner | io.resp_ready[owner]) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // NOTE: the hold registers are explicitly reset so resp_* reads 0 after reset, never stale data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner       <= '0;
      rrPtr       <= '0;
      opSqrt      <= 1'b0;
      tagQ        <= '0;
      wdog        <= '0;
      kill        <= 1'b0;
      timeout_err <= 1'b0;
      holdOut     <= '0;
      holdExc     <= '0;
      holdUExc    <= '0;
      holdUFlag   <= '0;
    end else begin
      case (stateQ)
        IDLE: if (grantValid) begin
          owner  <= grantIdx;
          opSqrt <= io.req_sqrt[grantIdx];
          tagQ   <= reqTag[grantIdx];
          rrPtr  <= (grantIdx == idx_t'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
          wdog   <= '0;
          kill   <= 1'b0;
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          if (completion) begin
            kill <= 1'b0;
            if (!(kill | flushOwner)) begin
              holdOut   <= io.ds_out;
              holdExc   <= io.ds_exc;
              holdUExc  <= io.ds_u_exc;
              holdUFlag <= io.ds_u_flag;
            end
          end else begin
            if (flushOwner) kill <= 1'b1;
            if (wdogDone) begin
              timeout_err <= 1'b1;
              kill        <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sqrt_issue_arbiter.sv
// Directed bench for div_sqrt_issue_arbiter: arbitration, type-ready skipping,
// flush, response back-pressure, watchdog and asynchronous reset.
module tb_div_sqrt_issue_arbiter;
  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 5;
  localparam int MAX_LAT = 127;

  localparam logic [64:0] A0 = 65'h1_2345_6789_ABCD_EF01;
  localparam logic [64:0] B0 = 65'h0_0F0F_1234_5555_AAAA;
  localparam logic [64:0] A1 = 65'h0_DEAD_BEEF_0BAD_F00D;
  localparam logic [64:0] B1 = 65'h1_CAFE_F00D_1357_9BDF;
  localparam logic [64:0] R0 = 65'h1_4010_0000_0000_0001;
  localparam logic [64:0] R1 = 65'h0_3FF8_0000_0000_0003;
  localparam logic [64:0] R2 = 65'h1_7777_6666_5555_4444;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy, timeout_err;
  int   checks   = 0;
  int   failures = 0;

  div_sqrt_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus();

  div_sqrt_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MAX_LAT(MAX_LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .io          (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid         = '0;
    bus.req_sqrt          = '0;
    bus.req_a             = '0;
    bus.req_b             = '0;
    bus.req_rm            = '0;
    bus.req_is_snan       = '0;
    bus.req_tag           = '0;
    bus.flush             = '0;
    bus.resp_ready        = '0;
    bus.ds_in_ready_div   = 1'b1;
    bus.ds_in_ready_sqrt  = 1'b1;
    bus.ds_out_valid_div  = 1'b0;
    bus.ds_out_valid_sqrt = 1'b0;
    bus.ds_out            = '0;
    bus.ds_exc            = '0;
    bus.ds_u_exc          = '0;
    bus.ds_u_flag         = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input logic sq, input logic [64:0] a,
                         input logic [64:0] b, input logic [2:0] rm, input logic [3:0] sn,
                         input logic [TAG_W-1:0] tag);
    bus.req_valid[i]               = v;
    bus.req_sqrt[i]                = sq;
    bus.req_a[65*i +: 65]          = a;
    bus.req_b[65*i +: 65]          = b;
    bus.req_rm[3*i +: 3]           = rm;
    bus.req_is_snan[4*i +: 4]      = sn;
    bus.req_tag[TAG_W*i +: TAG_W]  = tag;
  endtask

  // Drives a one-cycle result pulse across one clock edge, then scrambles the result bus.
  task automatic result_pulse(input logic sq, input logic [64:0] o, input logic [4:0] e,
                              input logic [6:0] ue, input logic [9:0] uf);
    bus.ds_out_valid_sqrt = sq;
    bus.ds_out_valid_div  = ~sq;
    bus.ds_out            = o;
    bus.ds_exc            = e;
    bus.ds_u_exc          = ue;
    bus.ds_u_flag         = uf;
    clk1();
    bus.ds_out_valid_sqrt = 1'b0;
    bus.ds_out_valid_div  = 1'b0;
    bus.ds_out            = ~o;
    bus.ds_exc            = ~e;
    bus.ds_u_exc          = ~ue;
    bus.ds_u_flag         = ~uf;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    clk1();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout_err); end
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.resp_valid !== 2'b00) begin failures++; $display("FAIL rst_resp_valid got=%b exp=00", bus.resp_valid); end
    checks++; if (bus.ds_in_valid !== 1'b0) begin failures++; $display("FAIL rst_ds_in_valid got=%b exp=0", bus.ds_in_valid); end
    checks++; if (bus.resp_out !== 65'h0) begin failures++; $display("FAIL rst_resp_out got=%h exp=0", bus.resp_out); end
    checks++; if (bus.resp_tag !== 5'h0) begin failures++; $display("FAIL rst_resp_tag got=%h exp=0", bus.resp_tag); end
    reset = 1'b1;
  endtask

  task automatic test_single_div();
    bus.resp_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd3, 4'h5, 5'h0B);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL t1_grant got=%b exp=01", bus.req_ready); end
    checks++; if (bus.ds_in_valid !== 1'b1) begin failures++; $display("FAIL t1_ds_in_valid got=%b exp=1", bus.ds_in_valid); end
    checks++; if (bus.ds_a !== A0 || bus.ds_b !== B0) begin failures++; $display("FAIL t1_operands got=%h/%h exp=%h/%h", bus.ds_a, bus.ds_b, A0, B0); end
    checks++; if (bus.ds_rm !== 3'd3 || bus.ds_is_snan !== 4'h5 || bus.ds_sqrt_op !== 1'b0) begin
      failures++; $display("FAIL t1_fields got=%h/%h/%b exp=3/5/0", bus.ds_rm, bus.ds_is_snan, bus.ds_sqrt_op); end
    clk1();
    bus.req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1 || bus.ds_in_valid !== 1'b0) begin failures++; $display("FAIL t1_busy got=%b/%b exp=1/0", busy, bus.ds_in_valid); end
    repeat (10) clk1();
    result_pulse(1'b0, R0, 5'h11, 7'h22, 10'h155);
    #1;
    checks++; if (bus.resp_valid !== 2'b01) begin failures++; $display("FAIL t1_resp_valid got=%b exp=01", bus.resp_valid); end
    checks++; if (bus.resp_out !== R0) begin failures++; $display("FAIL t1_resp_out got=%h exp=%h", bus.resp_out, R0); end
    checks++; if (bus.resp_tag !== 5'h0B) begin failures++; $display("FAIL t1_resp_tag got=%h exp=0b", bus.resp_tag); end
    checks++; if (bus.resp_exc !== 5'h11 || bus.resp_u_exc !== 7'h22 || bus.resp_u_flag !== 10'h155) begin
      failures++; $display("FAIL t1_resp_flags got=%h/%h/%h exp=11/22/155", bus.resp_exc, bus.resp_u_exc, bus.resp_u_flag); end
    clk1();
    checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0) begin failures++; $display("FAIL t1_done got=%b/%b exp=00/0", bus.resp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] expG;
    do_reset();
    bus.resp_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd0, 4'h0, 5'h01);
    set_req(1, 1'b1, 1'b0, A1, B1, 3'd1, 4'h0, 5'h02);
    for (int k = 0; k < 4; k++) begin
      expG = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++; if (bus.req_ready !== expG) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, expG); end
      checks++; if (bus.ds_a !== ((k % 2 == 0) ? A0 : A1)) begin failures++; $display("FAIL rr_ds_a%0d got=%h", k, bus.ds_a); end
      clk1();
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL rr_busy_ready%0d got=%b exp=00", k, bus.req_ready); end
      result_pulse(1'b0, R1, 5'h0, 7'h0, 10'h0);
      #1;
      checks++; if (bus.resp_valid !== expG) begin failures++; $display("FAIL rr_resp%0d got=%b exp=%b", k, bus.resp_valid, expG); end
      checks++; if (bus.resp_tag !== ((k % 2 == 0) ? 5'h01 : 5'h02)) begin failures++; $display("FAIL rr_tag%0d got=%h", k, bus.resp_tag); end
      clk1();
    end
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rr_wrap got=%b exp=01", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_type_ready();
    bus.resp_ready       = 2'b11;
    bus.ds_in_ready_sqrt = 1'b0;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd0, 4'h0, 5'h03);
    set_req(1, 1'b1, 1'b1, A1, B1, 3'd2, 4'h0, 5'h04);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL ty_grant_a got=%b exp=01", bus.req_ready); end
    clk1();
    result_pulse(1'b0, R0, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (bus.resp_valid !== 2'b01) begin failures++; $display("FAIL ty_resp_a got=%b exp=01", bus.resp_valid); end
    clk1();
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL ty_skip got=%b exp=01", bus.req_ready); end
    clk1();
    result_pulse(1'b0, R0, 5'h0, 7'h0, 10'h0);
    clk1();
    bus.ds_in_ready_sqrt = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b10 || bus.ds_sqrt_op !== 1'b1) begin
      failures++; $display("FAIL ty_grant_sqrt got=%b/%b exp=10/1", bus.req_ready, bus.ds_sqrt_op); end
    clk1();
    bus.req_valid = '0;
    result_pulse(1'b0, R2, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (busy !== 1'b1 || bus.resp_valid !== 2'b00) begin
      failures++; $display("FAIL ty_wrong_pulse got=%b/%b exp=1/00", busy, bus.resp_valid); end
    result_pulse(1'b1, R1, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (bus.resp_valid !== 2'b10 || bus.resp_tag !== 5'h04 || bus.resp_out !== R1) begin
      failures++; $display("FAIL ty_resp_sqrt got=%b/%h/%h exp=10/04/%h", bus.resp_valid, bus.resp_tag, bus.resp_out, R1); end
    clk1();
  endtask

  task automatic test_flush();
    bus.resp_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd0, 4'h0, 5'h09);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL fl_grant_a got=%b exp=01", bus.req_ready); end
    clk1();
    bus.req_valid = '0;
    clk1();
    clk1();
    bus.flush = 2'b01;
    clk1();
    bus.flush = 2'b00;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fl_still_busy got=%b exp=1", busy); end
    clk1();
    result_pulse(1'b0, R0, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00) begin
      failures++; $display("FAIL fl_dropped got=%b/%b exp=0/00", busy, bus.resp_valid); end
    set_req(1, 1'b1, 1'b0, A1, B1, 3'd0, 4'h0, 5'h0C);
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL fl_grant_b got=%b exp=10", bus.req_ready); end
    clk1();
    bus.req_valid = '0;
    bus.flush     = 2'b01;
    clk1();
    clk1();
    bus.flush = 2'b00;
    result_pulse(1'b0, R1, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (bus.resp_valid !== 2'b10 || bus.resp_out !== R1) begin
      failures++; $display("FAIL fl_nonowner got=%b/%h exp=10/%h", bus.resp_valid, bus.resp_out, R1); end
    clk1();
    bus.req_valid[0] = 1'b1;
    bus.flush        = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b00 || bus.ds_in_valid !== 1'b0) begin
      failures++; $display("FAIL fl_idle_block got=%b/%b exp=00/0", bus.req_ready, bus.ds_in_valid); end
    bus.flush     = 2'b00;
    bus.req_valid = '0;
  endtask

  task automatic test_resp_hold();
    bus.resp_ready = 2'b00;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd2, 4'h0, 5'h07);
    set_req(1, 1'b1, 1'b0, A1, B1, 3'd0, 4'h0, 5'h15);
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin failures++; $display("FAIL rh_grant got=%b exp=01", bus.req_ready); end
    clk1();
    bus.req_valid[0] = 1'b0;
    result_pulse(1'b0, R2, 5'h1F, 7'h7F, 10'h3FF);
    for (int k = 0; k < 5; k++) begin
      bus.ds_out = 65'(k);
      #1;
      checks++; if (bus.resp_valid !== 2'b01 || bus.resp_out !== R2 || bus.resp_tag !== 5'h07) begin
        failures++; $display("FAIL rh_stable%0d got=%b/%h/%h exp=01/%h/07", k, bus.resp_valid, bus.resp_out, bus.resp_tag, R2); end
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL rh_no_grant%0d got=%b exp=00", k, bus.req_ready); end
      clk1();
    end
    bus.resp_ready = 2'b01;
    clk1();
    checks++; if (bus.req_ready !== 2'b10 || bus.resp_valid !== 2'b00) begin
      failures++; $display("FAIL rh_next_grant got=%b/%b exp=10/00", bus.req_ready, bus.resp_valid); end
    clk1();
    bus.req_valid  = '0;
    bus.resp_ready = 2'b00;
    result_pulse(1'b0, R0, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (bus.resp_valid !== 2'b10) begin failures++; $display("FAIL rh_resp_b got=%b exp=10", bus.resp_valid); end
    bus.flush = 2'b10;
    clk1();
    bus.flush = 2'b00;
    checks++; if (bus.resp_valid !== 2'b00 || busy !== 1'b0) begin
      failures++; $display("FAIL rh_resp_flush got=%b/%b exp=00/0", bus.resp_valid, busy); end
  endtask

  task automatic test_watchdog_reset();
    bus.resp_ready = 2'b11;
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd0, 4'h0, 5'h01);
    clk1();
    bus.req_valid = '0;
    repeat (MAX_LAT - 1) clk1();
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      failures++; $display("FAIL wd_before got=%b/%b exp=1/0", busy, timeout_err); end
    clk1();
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b1 || bus.resp_valid !== 2'b00) begin
      failures++; $display("FAIL wd_fire got=%b/%b/%b exp=0/1/00", busy, timeout_err, bus.resp_valid); end
    set_req(1, 1'b1, 1'b0, A1, B1, 3'd0, 4'h0, 5'h02);
    clk1();
    bus.req_valid = '0;
    result_pulse(1'b0, R1, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (bus.resp_valid !== 2'b10) begin failures++; $display("FAIL wd_after_op got=%b exp=10", bus.resp_valid); end
    clk1();
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b exp=1", timeout_err); end
    set_req(0, 1'b1, 1'b0, A0, B0, 3'd0, 4'h0, 5'h03);
    clk1();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_busy got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0 || bus.req_ready !== 2'b00 || bus.ds_in_valid !== 1'b0) begin
      failures++; $display("FAIL ar_outputs got=%b/%b/%b/%b exp=0/0/00/0", busy, timeout_err, bus.req_ready, bus.ds_in_valid); end
    checks++; if (bus.resp_valid !== 2'b00 || bus.resp_out !== 65'h0 || bus.ds_a !== 65'h0) begin
      failures++; $display("FAIL ar_data got=%b/%h/%h exp=00/0/0", bus.resp_valid, bus.resp_out, bus.ds_a); end
    clk1();
    reset         = 1'b1;
    bus.req_valid = '0;
    result_pulse(1'b0, R2, 5'h0, 7'h0, 10'h0);
    #1;
    checks++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00) begin
      failures++; $display("FAIL ar_late_pulse got=%b/%b exp=0/00", busy, bus.resp_valid); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    clear_inputs();
    test_single_div();
    test_round_robin();
    test_type_ready();
    test_flush();
    test_resp_hold();
    test_watchdog_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
